// File: rtl/decode_stage.sv
// RV32/RV64 base-ISA decode stage behind a two-entry (main + skid) buffer.
// Decoded fields are captured at acceptance, so every out_* signal is a register.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int RV_M = 0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [9:0]      out_class,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_rd_we,
  output logic            out_illegal
);

  typedef enum logic [6:0] {
    OPC_REG    = 7'b0110011,
    OPC_IMM    = 7'b0010011,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_AUIPC  = 7'b0010111,
    OPC_LUI    = 7'b0110111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [9:0]      cls;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            illegal;
  } entry_t;

  localparam bit IS_RV32 = (XLEN == 32);
  localparam bit HAS_M   = (RV_M == 1);
  // Classes that write rd: alu_reg, alu_imm, jalr, jal, auipc, lui, load.
  localparam logic [9:0] WRITES_RD = 10'h0FB;

  entry_t             dec;
  entry_t             main_q;
  entry_t             skid_q;
  logic               main_v;
  logic               skid_v;
  logic               accept;
  logic signed [31:0] imm32;
  logic [2:0]         f3;
  logic [6:0]         f7;

  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  // Combinational decode of the instruction currently offered upstream.
  always_comb begin
    dec         = '0;
    imm32       = '0;
    dec.pc      = in_pc;
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.f3      = f3;
    dec.f7      = f7;
    unique case (in_instr[6:0])
      OPC_REG: begin
        dec.cls[0]  = 1'b1;
        dec.illegal = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                        (f7 == 7'b0000001 && HAS_M));
      end
      OPC_IMM: begin
        dec.cls[1] = 1'b1;
        imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
        if (f3 == 3'b001 || f3 == 3'b101)
          dec.illegal = !(in_instr[31:26] == 6'b000000 || in_instr[31:26] == 6'b010000) ||
                        (IS_RV32 && in_instr[25]);
      end
      OPC_BRANCH: begin
        dec.cls[2]  = 1'b1;
        imm32       = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
        dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JALR: begin
        dec.cls[3]  = 1'b1;
        imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.illegal = (f3 != 3'b000);
      end
      OPC_JAL: begin
        dec.cls[4] = 1'b1;
        imm32      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
      end
      OPC_AUIPC: begin
        dec.cls[5] = 1'b1;
        imm32      = {in_instr[31:12], 12'b0};
      end
      OPC_LUI: begin
        dec.cls[6] = 1'b1;
        imm32      = {in_instr[31:12], 12'b0};
      end
      OPC_LOAD: begin
        dec.cls[7]  = 1'b1;
        imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.illegal = (f3 == 3'b111) || (IS_RV32 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OPC_STORE: begin
        dec.cls[8]  = 1'b1;
        imm32       = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.illegal = f3[2] || (IS_RV32 && f3 == 3'b011);
      end
      OPC_SYSTEM: begin
        dec.cls[9] = 1'b1;
        imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm   = XLEN'(imm32);
    dec.rd_we = (|(dec.cls & WRITES_RD)) && (dec.rd != 5'd0) && !dec.illegal;
  end

  assign in_ready = !skid_v;
  assign accept   = in_valid && !skid_v;

  // Main/skid occupancy: main refills from skid first to keep program order;
  // a new entry goes to skid only while main is held by a stalled consumer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign out_valid   = main_v;
  assign out_pc      = main_q.pc;
  assign out_class   = main_q.cls;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct3  = main_q.f3;
  assign out_funct7  = main_q.f7;
  assign out_imm     = main_q.imm;
  assign out_rd_we   = main_q.rd_we;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV32 (RV_M=0) and an RV64 (RV_M=1) instance share
// one stimulus stream; expected entries are queued on acceptance and popped on output.
module tb_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [9:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        ir32, ov32, we32, ill32;
  logic [31:0] pc32, imm32;
  logic [9:0]  cls32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32;
  logic [6:0]  f7_32;

  logic        ir64, ov64, we64, ill64;
  logic [63:0] pc64, imm64;
  logic [9:0]  cls64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64;
  logic [6:0]  f7_64;

  int checks = 0;
  int errors = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RV_M(0)) dut32 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(ir32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
    .out_valid(ov32), .out_ready(out_ready), .out_pc(pc32), .out_class(cls32),
    .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32), .out_funct3(f3_32),
    .out_funct7(f7_32), .out_imm(imm32), .out_rd_we(we32), .out_illegal(ill32)
  );

  decode_stage #(.XLEN(64), .RV_M(1)) dut64 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(ir64),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(ov64), .out_ready(out_ready), .out_pc(pc64), .out_class(cls64),
    .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64), .out_funct3(f3_64),
    .out_funct7(f7_64), .out_imm(imm64), .out_rd_we(we64), .out_illegal(ill64)
  );

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference decode from the ISA rules, immediates built with signed arithmetic.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc,
                                 input bit x64, input bit rvm);
    exp_t   e;
    longint s;
    longint imm;
    int     idx;
    logic [2:0] f3;
    e   = '0;
    s   = longint'($signed(i));
    imm = 0;
    idx = -1;
    f3  = i[14:12];
    e.pc  = x64 ? pc : {32'b0, pc[31:0]};
    e.rd  = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.f3  = f3;
    e.f7  = i[31:25];
    case (i[6:0])
      7'b0110011: begin
        idx = 0;
        e.ill = !(i[31:25] == 0 || (i[31:25] == 7'h20 && (f3 == 0 || f3 == 5)) ||
                  (i[31:25] == 7'h01 && rvm));
      end
      7'b0010011: begin
        idx = 1; imm = s >>> 20;
        if (f3 == 1 || f3 == 5)
          e.ill = !(i[31:26] == 0 || i[31:26] == 6'h10) || (!x64 && i[25]);
      end
      7'b1100011: begin
        idx = 2;
        imm = ((s >>> 31) << 12) + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 +
              longint'(i[11:8]) * 2;
        e.ill = (f3 == 2 || f3 == 3);
      end
      7'b1100111: begin idx = 3; imm = s >>> 20; e.ill = (f3 != 0); end
      7'b1101111: begin
        idx = 4;
        imm = ((s >>> 31) << 20) + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 +
              longint'(i[30:21]) * 2;
      end
      7'b0010111: begin idx = 5; imm = (s >>> 12) << 12; end
      7'b0110111: begin idx = 6; imm = (s >>> 12) << 12; end
      7'b0000011: begin
        idx = 7; imm = s >>> 20;
        e.ill = (f3 == 7) || (!x64 && (f3 == 3 || f3 == 6));
      end
      7'b0100011: begin
        idx = 8; imm = ((s >>> 25) << 5) + longint'(i[11:7]);
        e.ill = (f3 >= 4) || (!x64 && f3 == 3);
      end
      7'b1110011: begin idx = 9; imm = s >>> 20; end
      default: e.ill = 1'b1;
    endcase
    if (idx >= 0) e.cls = 10'b1 << idx;
    e.imm = x64 ? imm : {32'b0, imm[31:0]};
    e.we  = (idx inside {0, 1, 3, 4, 5, 6, 7}) && (e.rd != 0) && !e.ill;
    return e;
  endfunction

  function automatic exp_t act32();
    exp_t a;
    a = '{pc: {32'b0, pc32}, cls: cls32, rd: rd32, rs1: rs1_32, rs2: rs2_32, f3: f3_32,
          f7: f7_32, imm: {32'b0, imm32}, we: we32, ill: ill32};
    return a;
  endfunction

  function automatic exp_t act64();
    exp_t a;
    a = '{pc: pc64, cls: cls64, rd: rd64, rs1: rs1_64, rs2: rs2_64, f3: f3_64,
          f7: f7_64, imm: imm64, we: we64, ill: ill64};
    return a;
  endfunction

  // Monitor: occupancy, ordering and payload against the queued expectations.
  always @(negedge clk) begin
    if (!resetn) begin
      q32.delete();
      q64.delete();
      check("reset_out_valid", {ov32, ov64}, 2'b00);
      check("reset_in_ready", {ir32, ir64}, 2'b11);
      check("reset_payload", {act32(), act64()}, '0);
    end else begin
      check("in_ready32", ir32, q32.size() < 2);
      check("in_ready64", ir64, q64.size() < 2);
      check("out_valid32", ov32, q32.size() != 0);
      check("out_valid64", ov64, q64.size() != 0);
      if (ov32 && out_ready && q32.size() != 0) check("entry32", act32(), q32.pop_front());
      if (ov64 && out_ready && q64.size() != 0) check("entry64", act64(), q64.pop_front());
      if (flush) begin
        q32.delete();
        q64.delete();
      end else begin
        if (in_valid && ir32) q32.push_back(model(in_instr, in_pc, 1'b0, 1'b0));
        if (in_valid && ir64) q64.push_back(model(in_instr, in_pc, 1'b1, 1'b1));
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = {$urandom, $urandom};
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opc [10] = '{7'h33, 7'h13, 7'h63, 7'h67, 7'h6F, 7'h17, 7'h37, 7'h03, 7'h23, 7'h73};
    logic [6:0]  f7s [4]  = '{7'h00, 7'h20, 7'h01, 7'h7F};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = opc[$urandom_range(0, 9)];
    if (r[6:0] == 7'h33) r[31:25] = f7s[$urandom_range(0, 3)];
    if (r[6:0] == 7'h13 && $urandom_range(0, 1) == 1) r[31:26] = $urandom_range(0, 1) ? 6'h10 : 6'h00;
    return r;
  endfunction

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;

    step(1, 32'hFFF10093, 1, 0);                       // addi x1,x2,-1
    check("addi_class", cls32, 10'b0000000010);
    check("addi_fields", {rd32, rs1_32}, {5'd1, 5'd2});
    check("addi_imm", imm32, 32'hFFFFFFFF);
    check("addi_we_ill", {we32, ill32}, 2'b10);
    step(1, 32'hFE000EE3, 1, 0);                       // beq x0,x0,-4
    check("beq_class", cls32, 10'b0000000100);
    check("beq_imm", imm32, 32'hFFFFFFFC);
    check("beq_we", we32, 1'b0);
    step(1, 32'h00000000, 1, 0);
    check("zero_illegal", {ill32, cls32}, {1'b1, 10'b0});
    step(1, 32'h022081B3, 1, 0);                       // mul x3,x1,x2
    check("mul_rv32", {ill32, we32}, 2'b10);
    check("mul_rvm", {ill64, we64}, 2'b01);
    step(1, 32'h800000B7, 1, 0);                       // lui x1,0x80000
    check("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    step(0, 0, 1, 0);

    // Stall: three offers while the consumer is blocked.
    step(1, 32'h00500113, 0, 0);
    step(1, 32'h00600193, 0, 0);
    check("stall_in_ready", {ir32, ir64}, 2'b00);
    step(1, 32'h00700213, 0, 0);
    check("stall_hold", {ir32, ov32, rd32}, {1'b0, 1'b1, 5'd2});
    step(0, 0, 1, 0);
    check("unstall_in_ready", {ir32, ov32, rd32}, {1'b1, 1'b1, 5'd3});
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Flush while both entries are full, alongside a new offer.
    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00200113, 0, 0);
    step(1, 32'h00300193, 0, 1);
    check("flush_state", {ov32, ir32, ov64, ir64}, 4'b0101);
    step(0, 0, 1, 0);
    check("flush_dropped", ov32, 1'b0);

    // Asynchronous reset while holding two entries.
    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00200113, 0, 0);
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("async_reset", {ov32, ir32, imm32, ov64, ir64}, {1'b0, 1'b1, 32'h0, 1'b0, 1'b1});
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00A00513; out_ready = 1'b1;
    @(posedge clk); #1;
    check("first_after_reset", {ov32, rd32, imm32}, {1'b1, 5'd10, 32'd10});

    for (int n = 0; n < 1500; n++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0);

    repeat (4) step(0, 0, 1, 0);
    check("drained", {q32.size(), q64.size()}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32; legal values are 32 and 64; it sets the datapath width for pc and imm.
REQ-002 SHALL have parameter RV_M, default 0; a value of 1 accepts M-extension register ops as legal.
REQ-003 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have input-side ports:
- in_valid  input  1  upstream offers an instruction.
- in_ready  output  1  stage can accept.
- in_instr  input  32  raw instruction.
- in_pc  input  XLEN  instruction address.
- flush  input  1  synchronous kill of all held entries.
REQ-005 SHALL have output-side ports:
- out_valid  output  1  decoded entry presented.
- out_ready  input  1  downstream accepts.
- out_pc  output  XLEN  address carried through unchanged.
- out_class  output  10  one-hot: bit0 alu_reg, 1 alu_imm, 2 branch, 3 jalr, 4 jal, 5 auipc, 6 lui, 7 load, 8 store, 9 system.
- out_rd, out_rs1, out_rs2  output  5 each  instr[11:7], [19:15], [24:20].
- out_funct3  output  3  instr[14:12].
- out_funct7  output  7  instr[31:25].
- out_imm  output  XLEN  sign-extended immediate.
- out_rd_we  output  1  destination write enable.
- out_illegal  output  1  instruction not legal.

Function
REQ-006 SHALL decode classes from opcode instr[6:0]: 0110011, 0010011, 1100011, 1100111, 1101111, 0010111, 0110111, 0000011, 0100011, 1110011, mapped to out_class bits 0..9 respectively.
REQ-007 SHALL drive out_class to all-zero and set out_illegal for any other opcode, including any opcode with instr[1:0] != 11.
REQ-008 SHALL form out_imm by instruction format, sign bit instr[31], extended to XLEN:
- I format (alu_imm, jalr, load, system).
- S format (store).
- B format (branch), bit0 = 0.
- U format (lui, auipc): instr[31:12] << 12.
- J format (jal), bit0 = 0.
- 0 for alu_reg.
REQ-009 SHALL set out_illegal for alu_reg when funct7 is not one of:
- 0000000;
- 0100000 with funct3 in {000, 101};
- 0000001 with RV_M = 1.
REQ-010 SHALL set out_illegal for these field violations:
- alu_imm shift (funct3 001/101) with instr[31:26] not 000000 or 010000; if XLEN = 32, also when instr[25] = 1.
- branch funct3 010 or 011.
- load funct3 111; and load funct3 011 or 110 when XLEN = 32.
- store funct3 >= 100; and store funct3 011 when XLEN = 32.
- jalr funct3 != 000.
REQ-011 SHALL assert out_rd_we only for classes alu_reg, alu_imm, jalr, jal, auipc, lui and load, only when rd != 0, and never when out_illegal = 1.

Handshake and buffering
REQ-012 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-013 SHALL hold two entries, main and skid, and drive in_ready = !skid_full from a register (no combinational path from out_ready).
REQ-014 SHALL present an accepted instruction on the outputs the cycle after acceptance, with latency 1 and throughput 1 per cycle while out_ready = 1.
REQ-015 SHALL behave as follows when out_ready = 0 with main full:
- a transfer in that cycle goes to skid;
- in_ready is 0 on the next cycle.
REQ-016 SHALL, on an output transfer while skid is full, move skid to main and raise in_ready the next cycle.
REQ-017 SHALL preserve program order; no entry may be dropped or duplicated.
REQ-018 SHALL keep all out_* payload stable while out_valid && !out_ready.
REQ-019 SHALL, on flush = 1:
- empty both entries at the next edge, so out_valid = 0 and in_ready = 1;
- discard any input transfer in that same cycle;
- give flush priority over simultaneous input and output transfers.

Reset
REQ-020 SHALL, with resetn low, immediately force:
- out_valid = 0 and in_ready = 1;
- both entries empty;
- all payload outputs to 0.
REQ-021 SHALL discard in-flight entries on reset asserted mid-operation, and accept input on the first clk edge after resetn rises.

Verification
REQ-022 SHALL cover these directed scenarios:
- addi x1,x2,-1 (0xFFF10093), out_ready = 1 -> next cycle out_class bit1, rd = 1, rs1 = 2, imm = 0xFFFFFFFF, rd_we = 1, illegal = 0.
- beq x0,x0,-4 (0xFE000EE3) -> class bit2, imm = 0xFFFFFFFC, rd_we = 0; 0x00000000 -> illegal = 1, class = 0.
- mul x3,x1,x2 (0x022081B3) -> RV_M = 0: illegal = 1, rd_we = 0; RV_M = 1: illegal = 0, rd_we = 1.
- out_ready = 0, three back-to-back valid inputs -> two accepted, in_ready = 0 from cycle 3; then out_ready = 1 -> entries emerge in order, in_ready = 1 the cycle after the first output transfer.
- Stall with both entries full, flush pulsed alongside in_valid -> next cycle out_valid = 0, in_ready = 1, flushed-cycle instruction never emerges.
- resetn dropped while holding two entries -> out_valid = 0 and in_ready = 1 asynchronously; XLEN = 64 run of lui 0x80000 -> imm = 0xFFFFFFFF80000000.
